conv3x3_stream: RTL and testbench
=================================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, 16: pixels per stream beat, power of 2, 2..64.
REQ-002 SHALL have parameter IMAGE_W, 512: frame width in pixels, multiple of PIXELS_PER_BEAT.
REQ-003 SHALL have parameter IMAGE_H, 512: frame height in rows, >=3.
REQ-004 SHALL have parameter PIXEL_WIDTH, 8: unsigned bits per pixel.
REQ-005 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-006 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port mode, input, 2: 0=L1 Sobel |gx|+|gy|, 1=|gx|, 2=|gy|, 3=programmable kernel.
REQ-008 SHALL have port coeff, input, 36: nine 4-bit signed taps, k00 in [3:0] row-major to k22 in [35:32].
REQ-009 SHALL have port shift, input, 3: right shift applied to mode-3 result.
REQ-010 SHALL have port s_valid / s_ready, input / output, 1 each: input beat handshake.
REQ-011 SHALL have port s_data, input, PIXELS_PER_BEAT*PIXEL_WIDTH: pixels, leftmost at MSBs.
REQ-012 SHALL have port m_valid / m_ready, output / input, 1 each: output beat handshake.
REQ-013 SHALL have port m_data, output, PIXELS_PER_BEAT*PIXEL_WIDTH: results, same ordering as s_data.
REQ-014 SHALL have port m_last, output, 1: high on the final beat of each output row.
REQ-015 SHALL have port m_sof, output, 1: high on the first beat of each output frame.

Function
REQ-016 SHALL transfer on a channel only in cycles where valid and ready are both high.
REQ-017 SHALL output one frame of IMAGE_H rows x IMAGE_W pixels per input frame; output pixel (r,c) is the 3x3 window centred on input (r,c).
REQ-018 SHALL treat every out-of-frame neighbour, top/bottom/left/right, as zero.
REQ-019 SHALL store two previous rows in internal line buffers of IMAGE_W/PIXELS_PER_BEAT entries each, rotating roles at each row end.
REQ-020 SHALL obtain horizontal neighbours across beat boundaries by holding one previous beat per row, so output beat b of a row is produced after input beat b+1 arrives, or at row end for the last beat.
REQ-021 SHALL implement states FILL (row 0 accepted, no output), RUN (row r accepted, row r-1 output), FLUSH (s_ready=0, row IMAGE_H-1 output with zero bottom row), then return to FILL.
REQ-022 SHALL latch mode, coeff and shift on the first accepted beat of each frame and ignore changes until the next frame.
REQ-023 SHALL use gx = right column minus left column with weights 1,2,1 and gy = bottom row minus top row with weights 1,2,1, computed at full signed precision.
REQ-024 SHALL saturate results to [0, 2^PIXEL_WIDTH-1]; modes 0-2 use absolute values, mode 3 is sum >>> shift (arithmetic), clamping negatives to 0.
REQ-025 SHALL pipeline arithmetic with a fixed depth of 3 registered stages, all advancing only when the output register is empty or m_ready=1.
REQ-026 SHALL deassert s_ready whenever the pipeline cannot advance, and never drop or duplicate beats under any m_ready pattern.
REQ-027 SHALL hold m_data, m_last and m_sof stable while m_valid=1 and m_ready=0.
REQ-028 SHALL accept the next frame's first beat in the cycle after the FLUSH state's final output beat enters the pipeline.

Reset
REQ-029 SHALL, when aresetn=0 at a clock edge, set state to FILL, row and column counters to 0, m_valid, m_last and m_sof to 0, and s_ready to 0.
REQ-030 SHALL assert s_ready in the first cycle after reset release.
REQ-031 SHALL discard any partial frame on reset mid-operation; line-buffer contents need not be cleared.
REQ-032 SHALL NOT have m_data defined until the first m_valid; the bench ignores m_data while m_valid=0.

Verification
REQ-033 SHALL pass: constant 100 frame, mode 0 -> interior outputs 0; corner pixel (0,0) = 255 (|300|+|300| saturated).
REQ-034 SHALL pass: horizontal ramp pixel=c mod 256, mode 1 -> interior outputs 8 away from the wrap column.
REQ-035 SHALL pass: mode 3 with k11=1 and others 0, shift=0 -> output frame equals input frame bit-exact.
REQ-036 SHALL pass: random m_ready at 30% duty and random s_valid gaps -> output matches golden model; m_last count is IMAGE_H and m_sof count is 1 per frame.
REQ-037 SHALL pass: mode changed mid-frame -> current frame uses the old mode; the next frame uses the new mode.
REQ-038 SHALL pass: reset asserted in the middle of row 5 -> first frame after reset matches golden model from a clean start.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a PIXELS_PER_BEAT-wide pixel stream.
// Two line buffers hold the previous rows. One previous column-stack is held so
// each output beat sees its left and right neighbours across beat boundaries.
// Each lane runs a fixed 3-stage datapath: window, sums, saturate.

module conv3x3_lane #(
  parameter int PW = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [2:0][2:0][PW-1:0] px,   // [row][col], col 0 = left
  input  logic [35:0]          coeff,
  input  logic [1:0]           mode,
  input  logic [2:0]           shift,
  output logic [PW-1:0]        res
);
  localparam int SW = PW + 8;  // fits 9 taps * |-8| * max pixel, signed

  logic signed [SW-1:0] gx_d, gy_d, ks_d, gx_q, gy_q, ks_q;
  logic signed [SW-1:0] pv, tv, ax, ay, v, maxv;
  logic [PW-1:0]        res_d;

  // full-precision Sobel and kernel sums over the window
  always_comb begin
    gx_d = '0;
    gy_d = '0;
    ks_d = '0;
    pv   = '0;
    tv   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pv = $signed({8'd0, px[r][c]});
        tv = $signed({{(SW-4){coeff[(r*3+c)*4+3]}}, coeff[(r*3+c)*4 +: 4]});
        ks_d = ks_d + tv * pv;
        if (c == 2) gx_d = gx_d + ((r == 1) ? (pv <<< 1) : pv);
        if (c == 0) gx_d = gx_d - ((r == 1) ? (pv <<< 1) : pv);
        if (r == 2) gy_d = gy_d + ((c == 1) ? (pv <<< 1) : pv);
        if (r == 0) gy_d = gy_d - ((c == 1) ? (pv <<< 1) : pv);
      end
    end
  end

  // mode select and saturation to the pixel range
  always_comb begin
    maxv = '0;
    maxv[PW-1:0] = '1;
    ax = gx_q[SW-1] ? -gx_q : gx_q;
    ay = gy_q[SW-1] ? -gy_q : gy_q;
    case (mode)
      2'd0:    v = ax + ay;
      2'd1:    v = ax;
      2'd2:    v = ay;
      default: v = ks_q >>> shift;
    endcase
    if (v[SW-1]) v = '0;
    res_d = (v > maxv) ? maxv[PW-1:0] : v[PW-1:0];
  end

  // stage 2 (sums) and stage 3 (result) registers
  always_ff @(posedge clk) begin
    if (en) begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      ks_q <= ks_d;
      res  <= res_d;
    end
  end
endmodule

module conv3x3_stream #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_W         = 512,
  parameter int IMAGE_H         = 512,
  parameter int PIXEL_WIDTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic [1:0]                             mode,
  input  logic [35:0]                            coeff,
  input  logic [2:0]                             shift,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] s_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] m_data,
  output logic                                   m_last,
  output logic                                   m_sof
);
  localparam int P  = PIXELS_PER_BEAT;
  localparam int PW = PIXEL_WIDTH;
  localparam int NB = IMAGE_W / P;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = $clog2(IMAGE_H + 1);

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
  typedef logic [P-1:0][PW-1:0] beat_t;

  state_t        state, state_nx;
  logic [RW-1:0] row;         // input row being accepted; IMAGE_H once flushing
  logic [CW-1:0] col;
  logic          col_end, tail, sel, first_out;
  logic          adv, in_fire, flush_step, tail_step, gen, out_new;

  beat_t lb0 [NB];
  beat_t lb1 [NB];
  logic [2:0][P-1:0][PW-1:0] stack, hold_c;  // [0]=top, [1]=mid, [2]=bottom
  logic [2:0][PW-1:0]        hold_edge;      // right pixel of the stack before hold_c
  logic [2:0][P+1:0][PW-1:0] win_nx, win_q;  // {left edge, centre beat, right edge}

  logic [1:0]  cfg_mode, mode1, mode2;
  logic [35:0] cfg_coeff, coeff1;
  logic [2:0]  cfg_shift, shift1, shift2;
  logic [3:1]  vld_pipe, last_pipe, sof_pipe;

  assign col_end = (col == CW'(NB - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!aresetn) state <= FILL;
    else          state <= state_nx;
  end

  // next state: row 0 fills, RUN ends after the tail of the last input row, FLUSH ends on its tail
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (in_fire && col_end) state_nx = RUN;
      RUN:     if (tail_step && row == RW'(IMAGE_H)) state_nx = FLUSH;
      FLUSH:   if (tail_step) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // handshake and step strobes; a tail cycle emits the last beat of a row with a zero right edge
  always_comb begin
    adv        = !vld_pipe[3] || m_ready;
    s_ready    = aresetn && adv && !tail && (state == FILL || state == RUN);
    in_fire    = s_valid && s_ready;
    flush_step = (state == FLUSH) && adv && !tail;
    tail_step  = adv && tail;
    gen        = in_fire || flush_step;
    out_new    = (gen && col != '0 && state != FILL) || tail_step;
  end

  // row/column sequencing, buffer role swap and tail scheduling
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      row       <= '0;
      col       <= '0;
      tail      <= 1'b0;
      sel       <= 1'b0;
      first_out <= 1'b0;
    end else begin
      if (gen) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) begin
          if (state != FLUSH) sel <= ~sel;
          if (state == FILL) begin
            row       <= RW'(1);
            first_out <= 1'b1;
          end else begin
            tail <= 1'b1;
            if (state == RUN) row <= row + 1'b1;
          end
        end
      end
      if (out_new) first_out <= 1'b0;
      if (tail_step) begin
        tail <= 1'b0;
        if (state == FLUSH) row <= '0;
      end
    end
  end

  // the incoming row overwrites the oldest row (the "top" buffer)
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (sel) lb0[col] <= s_data;
      else     lb1[col] <= s_data;
    end
  end

  // column stack for this step and the window of the beat one to the left
  always_comb begin
    stack[0] = sel ? lb0[col] : lb1[col];
    if (state == RUN && row == RW'(1)) stack[0] = '0;  // above output row 0
    stack[1] = sel ? lb1[col] : lb0[col];
    stack[2] = (state == FLUSH) ? '0 : s_data;
    for (int r = 0; r < 3; r++)
      win_nx[r] = {hold_edge[r], hold_c[r], tail ? {PW{1'b0}} : stack[r][P-1]};
  end

  // keep the previous stack and its right-most pixels for the next window
  always_ff @(posedge clk) begin
    if (gen) begin
      hold_c <= stack;
      for (int r = 0; r < 3; r++) hold_edge[r] <= (col == '0) ? '0 : hold_c[r][0];
    end
  end

  // configuration is frozen at the first beat of each frame
  always_ff @(posedge clk) begin
    if (in_fire && state == FILL && col == '0) begin
      cfg_mode  <= mode;
      cfg_coeff <= coeff;
      cfg_shift <= shift;
    end
  end

  // valid / last / sof shift registers alongside the datapath
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      sof_pipe  <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[2:1], out_new};
      last_pipe <= {last_pipe[2:1], tail_step};
      sof_pipe  <= {sof_pipe[2:1], out_new && first_out};
    end
  end

  // stage 1 window and per-stage copies of the frame configuration
  always_ff @(posedge clk) begin
    if (adv) begin
      win_q  <= win_nx;
      mode1  <= cfg_mode;
      coeff1 <= cfg_coeff;
      shift1 <= cfg_shift;
      mode2  <= mode1;
      shift2 <= shift1;
    end
  end

  assign m_valid = vld_pipe[3];
  assign m_last  = last_pipe[3];
  assign m_sof   = sof_pipe[3];

  for (genvar k = 0; k < P; k++) begin : g_lane
    logic [2:0][2:0][PW-1:0] lpx;
    // lane k's 3x3 neighbourhood from the stage-1 window
    always_comb begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          lpx[r][c] = win_q[r][k+2-c];
    end
    conv3x3_lane #(.PW(PW)) u_lane (
      .clk   (clk),
      .en    (adv),
      .px    (lpx),
      .coeff (coeff1),
      .mode  (mode2),
      .shift (shift2),
      .res   (m_data[k*PW +: PW])
    );
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: random frames against an arithmetic 3x3 reference.
module tb_conv3x3_stream;
  localparam int P = 4, W = 16, H = 8, PW = 8;
  localparam int NB = W / P, BW = P * PW, MAXP = (1 << PW) - 1, LIMIT = 2000;

  logic clk = 1'b0;
  logic aresetn, s_valid, s_ready, m_valid, m_ready, m_last, m_sof;
  logic [1:0] mode;
  logic [35:0] coeff;
  logic [2:0] shift;
  logic [BW-1:0] s_data, m_data;

  int err = 0, chk = 0;
  int img [H][W];
  int got [H][W];
  logic [BW+1:0] exp_q [$];
  int n_last = 0, n_sof = 0, mon_beats = 0;
  int rdy_pct = 100, gap_pct = 0;
  bit chk_en = 0, stall_prev = 0;
  logic [BW+1:0] prev_o, cur_o, e_o;

  always #5 clk = ~clk;

  conv3x3_stream #(.PIXELS_PER_BEAT(P), .IMAGE_W(W), .IMAGE_H(H), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .aresetn(aresetn), .mode(mode), .coeff(coeff), .shift(shift),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_sof(m_sof));

  function automatic int pix(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r][c];
  endfunction

  function automatic int ref_px(int r, int c, logic [1:0] md, logic [35:0] cf, logic [2:0] sh);
    int gx = 0, gy = 0, ks = 0, v, k;
    logic [3:0] nib;
    for (int d = -1; d <= 1; d++) begin
      gx += ((d == 0) ? 2 : 1) * (pix(r + d, c + 1) - pix(r + d, c - 1));
      gy += ((d == 0) ? 2 : 1) * (pix(r + 1, c + d) - pix(r - 1, c + d));
    end
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        nib = cf[((dr + 1) * 3 + dc + 1) * 4 +: 4];
        k = nib[3] ? int'(nib) - 16 : int'(nib);
        ks += k * pix(r + dr, c + dc);
      end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (md)
      2'd0: v = gx + gy;
      2'd1: v = gx;
      2'd2: v = gy;
      default: v = ks >>> sh;
    endcase
    if (v < 0) v = 0;
    if (v > MAXP) v = MAXP;
    return v;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    chk++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(logic [1:0] md, logic [35:0] cf, logic [2:0] sh);
    logic [BW-1:0] d;
    for (int r = 0; r < H; r++)
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < P; i++) d[(P-1-i)*PW +: PW] = PW'(ref_px(r, b*P + i, md, cf, sh));
        exp_q.push_back({d, b == NB - 1, r == 0 && b == 0});
      end
  endtask

  task automatic fill_img(int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 0) ? 100 : (kind == 1) ? (c % 256) : int'($urandom_range(0, MAXP));
  endtask

  // entered and left at posedge+#1
  task automatic send_frame(int stop_at, int chg_at, logic [1:0] chg_mode);
    int n;
    for (int idx = 0; idx < H * NB && idx < stop_at; idx++) begin
      if (idx == chg_at) mode = chg_mode;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < P; i++)
        s_data[(P-1-i)*PW +: PW] = PW'(img[idx / NB][(idx % NB) * P + i]);
      s_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (s_ready || n > LIMIT) break;
        n++;
      end
      check("s_ready_wait", n > LIMIT, 0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < LIMIT * 10) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(logic [1:0] md, logic [35:0] cf, logic [2:0] sh);
    mode = md; coeff = cf; shift = sh;
    n_last = 0; n_sof = 0;
    push_frame(md, cf, sh);
    send_frame(H * NB, -1, 2'd0);
    drain();
    check("m_last_count", n_last, H);
    check("m_sof_count", n_sof, 1);
  endtask

  // downstream back-pressure
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // output monitor: scoreboard, hold-while-stalled, frame capture
  initial begin
    forever begin
      @(negedge clk);
      cur_o = {m_data, m_last, m_sof};
      if (chk_en && stall_prev) begin
        chk++;
        assert (m_valid === 1'b1 && cur_o === prev_o) else begin
          err++;
          $error("FAIL stall_hold observed=%0h expected=%0h", cur_o, prev_o);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_o = cur_o;
      if (chk_en && m_valid && m_ready) begin
        for (int i = 0; i < P; i++)
          got[mon_beats / NB][(mon_beats % NB) * P + i] = int'(m_data[(P-1-i)*PW +: PW]);
        chk++;
        if (exp_q.size() == 0) begin
          err++;
          $error("FAIL extra_beat observed=%0h expected=none", cur_o);
        end else begin
          e_o = exp_q.pop_front();
          assert (cur_o === e_o) else begin
            err++;
            $error("FAIL beat%0d observed=%0h expected=%0h", mon_beats, cur_o, e_o);
          end
        end
        n_last += int'(m_last);
        n_sof += int'(m_sof);
        mon_beats = (mon_beats + 1) % (H * NB);
      end
    end
  end

  initial begin
    logic [35:0] cf;
    int bad;
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0;
    mode = 2'd0; coeff = '0; shift = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {s_ready, m_valid, m_last, m_sof}, 4'b0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1);
    @(posedge clk); #1; chk_en = 1;

    // constant frame, Sobel L1: flat interior, saturated corners
    fill_img(0);
    run_frame(2'd0, 36'd0, 3'd0);
    check("const_corner00", got[0][0], 255);
    check("const_interior", got[3][5], 0);
    check("const_cornerHW", got[H-1][W-1], 255);

    // horizontal ramp, |gx|
    fill_img(1);
    run_frame(2'd1, 36'd0, 3'd0);
    check("ramp_interior", got[3][5], 8);
    check("ramp_beat_seam", got[4][P], 8);
    check("ramp_left_edge", got[3][0], 4);
    check("ramp_right_edge", got[3][W-1], 56);

    // identity kernel reproduces the input
    fill_img(2);
    run_frame(2'd3, 36'h1 << 16, 3'd0);
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (got[r][c] != img[r][c]) bad++;
    check("identity_frame", bad, 0);

    // random back-pressure and input gaps, random configuration
    rdy_pct = 30; gap_pct = 40;
    for (int f = 0; f < 3; f++) begin
      fill_img(2);
      cf[31:0] = $urandom;
      cf[35:32] = 4'($urandom_range(0, 15));
      run_frame(2'($urandom_range(0, 3)), cf, 3'($urandom_range(0, 7)));
    end

    // mode changed mid-frame takes effect on the next frame only; frames back to back
    fill_img(2);
    mode = 2'd1; n_last = 0; n_sof = 0;
    push_frame(2'd1, coeff, shift);
    send_frame(H * NB, 10, 2'd2);
    fill_img(2);
    push_frame(2'd2, coeff, shift);
    send_frame(H * NB, -1, 2'd2);
    drain();
    check("b2b_m_last_count", n_last, 2 * H);
    check("b2b_m_sof_count", n_sof, 2);

    // reset in the middle of row 5, then a clean frame
    chk_en = 0;
    exp_q.delete();
    fill_img(2);
    send_frame(5 * NB + 2, -1, 2'd0);
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", {s_ready, m_valid, m_last, m_sof}, 4'b0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk);
    check("midreset_s_ready", s_ready, 1);
    @(posedge clk); #1;
    mon_beats = 0; chk_en = 1;
    fill_img(2);
    run_frame(2'd0, 36'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
